// File: rtl/fir_mac_secuenciador_pkg.sv
// Shared types and defaults for the FIR MAC sequencer: state encoding,
// parameter defaults and a constant clog2 helper for address widths.
package fir_mac_secuenciador_pkg;

  localparam int N_DEF    = 24;
  localparam int TAPS_DEF = 8;
  localparam int FRAC_DEF = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/fir_mac_secuenciador_linea_retardo.sv
// Sample delay line plus coefficient register file, with a shared read mux
// selecting one tap's sample and coefficient by index.
module fir_mac_secuenciador_linea_retardo
  import fir_mac_secuenciador_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int TAPS = TAPS_DEF,
  parameter int AW   = clog2(TAPS_DEF)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          shift_i,
  input  logic [N-1:0]  muestra_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [N-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [N-1:0]  x_o,
  output logic [N-1:0]  c_o
);

  logic [N-1:0] x_q [TAPS];
  logic [N-1:0] c_q [TAPS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < TAPS; i++) begin
        x_q[i] <= '0;
        c_q[i] <= '0;
      end
    end else begin
      if (shift_i) begin
        x_q[0] <= muestra_i;
        for (int i = 1; i < TAPS; i++) x_q[i] <= x_q[i-1];
      end
      if (we_i) c_q[waddr_i] <= wdata_i;
    end
  end

  assign x_o = x_q[raddr_i];
  assign c_o = c_q[raddr_i];

endmodule

// File: rtl/fir_mac_secuenciador.sv
// FIR sequencer around an external combinational MAC: walks the taps one per
// clock, then scales and saturates the accumulated sum to an N-bit output.
module fir_mac_secuenciador
  import fir_mac_secuenciador_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int TAPS = TAPS_DEF,
  parameter int FRAC = FRAC_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N-1:0]             muestra_in,
  input  logic                     muestra_valid,
  input  logic                     coef_we,
  input  logic [clog2(TAPS)-1:0]   coef_addr,
  input  logic [N-1:0]             coef_data,
  output logic [N-1:0]             Multiplicandos,
  output logic [N-1:0]             Constantes,
  output logic [2*N-1:0]           Sum_ext,
  input  logic [2*N-1:0]           Suma_G,
  output logic                     busy,
  output logic [N-1:0]             y_out,
  output logic                     y_valid,
  output logic                     sat
);

  localparam int AW = clog2(TAPS);

  state_e          state_q, state_d;
  logic [2*N-1:0]  acc_q, acc_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [N-1:0]    y_out_q, y_out_d;
  logic            y_valid_q, y_valid_d;
  logic            sat_q, sat_d;
  logic            shift, coefWrite;
  logic [N-1:0]    xRd, cRd;
  logic [2*N-1:0]  scaled;

  fir_mac_secuenciador_linea_retardo #(
    .N    (N),
    .TAPS (TAPS),
    .AW   (AW)
  ) u_linea (
    .clk       (clk),
    .reset     (reset),
    .shift_i   (shift),
    .muestra_i (muestra_in),
    .we_i      (coefWrite),
    .waddr_i   (coef_addr),
    .wdata_i   (coef_data),
    .raddr_i   (idx_q),
    .x_o       (xRd),
    .c_o       (cRd)
  );

  assign scaled = acc_q >> FRAC;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      idx_q     <= '0;
      y_out_q   <= '0;
      y_valid_q <= 1'b0;
      sat_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      idx_q     <= idx_d;
      y_out_q   <= y_out_d;
      y_valid_q <= y_valid_d;
      sat_q     <= sat_d;
    end
  end

  // MAC operands are only exposed while walking taps; zero elsewhere.
  always_comb begin
    state_d        = state_q;
    acc_d          = acc_q;
    idx_d          = idx_q;
    y_out_d        = y_out_q;
    y_valid_d      = 1'b0;
    sat_d          = sat_q;
    shift          = 1'b0;
    coefWrite      = 1'b0;
    Multiplicandos = '0;
    Constantes     = '0;
    Sum_ext        = '0;
    case (state_q)
      IDLE: begin
        coefWrite = coef_we && (int'(coef_addr) < TAPS);
        if (muestra_valid) begin
          shift   = 1'b1;
          acc_d   = '0;
          idx_d   = '0;
          state_d = MAC;
        end
      end
      MAC: begin
        Multiplicandos = xRd;
        Constantes     = cRd;
        Sum_ext        = acc_q;
        acc_d          = Suma_G;
        idx_d          = idx_q + AW'(1);
        if (idx_q == AW'(TAPS - 1)) state_d = OUT;
      end
      OUT: begin
        if (|scaled[2*N-1:N]) begin
          y_out_d = '1;
          sat_d   = 1'b1;
        end else begin
          y_out_d = scaled[N-1:0];
          sat_d   = 1'b0;
        end
        y_valid_d = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy    = (state_q != IDLE);
  assign y_out   = y_out_q;
  assign y_valid = y_valid_q;
  assign sat     = sat_q;

endmodule

// File: tb/tb_fir_mac_secuenciador.sv
// Self-checking bench for fir_mac_secuenciador: models the external MAC and
// compares every output sample against a direct sum-of-products reference.
module tb_fir_mac_secuenciador;
  import fir_mac_secuenciador_pkg::*;

  localparam int N    = 24;
  localparam int TAPS = 8;
  localparam int FRAC = 10;
  localparam int AW   = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    muestra_in;
  logic            muestra_valid;
  logic            coef_we;
  logic [AW-1:0]   coef_addr;
  logic [N-1:0]    coef_data;
  logic [N-1:0]    Multiplicandos;
  logic [N-1:0]    Constantes;
  logic [2*N-1:0]  Sum_ext;
  logic [2*N-1:0]  Suma_G;
  logic            busy;
  logic [N-1:0]    y_out;
  logic            y_valid;
  logic            sat;

  int testCount = 0;
  int failCount = 0;

  logic [N-1:0] xm [TAPS];
  logic [N-1:0] cm [TAPS];
  logic [N-1:0] expY;
  logic         expSat;
  int           lat;

  fir_mac_secuenciador #(.N(N), .TAPS(TAPS), .FRAC(FRAC)) dut (
    .clk            (clk),
    .reset          (reset),
    .muestra_in     (muestra_in),
    .muestra_valid  (muestra_valid),
    .coef_we        (coef_we),
    .coef_addr      (coef_addr),
    .coef_data      (coef_data),
    .Multiplicandos (Multiplicandos),
    .Constantes     (Constantes),
    .Sum_ext        (Sum_ext),
    .Suma_G         (Suma_G),
    .busy           (busy),
    .y_out          (y_out),
    .y_valid        (y_valid),
    .sat            (sat)
  );

  // Behavioural stand-in for the external Sumador MAC.
  assign Suma_G = Sum_ext + (48'(Multiplicandos) * 48'(Constantes));

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic void modelY(output logic [N-1:0] y, output logic s);
    logic [47:0] acc;
    logic [47:0] sc;
    acc = '0;
    for (int i = 0; i < TAPS; i++) acc = acc + 48'(xm[i]) * 48'(cm[i]);
    sc = acc >> FRAC;
    if (sc >= 48'h1000000) begin
      y = 24'hFFFFFF;
      s = 1'b1;
    end else begin
      y = sc[N-1:0];
      s = 1'b0;
    end
  endfunction

  task automatic modelShift(input logic [N-1:0] v);
    for (int i = TAPS - 1; i > 0; i--) xm[i] = xm[i-1];
    xm[0] = v;
  endtask

  task automatic modelClear;
    for (int i = 0; i < TAPS; i++) begin
      xm[i] = '0;
      cm[i] = '0;
    end
  endtask

  task automatic doReset;
    reset = 1'b1;
    tick;
    @(negedge clk);
    reset = 1'b0;
    modelClear();
  endtask

  task automatic writeCoef(input int addr, input logic [N-1:0] data);
    coef_we   = 1'b1;
    coef_addr = AW'(addr);
    coef_data = data;
    tick;
    coef_we = 1'b0;
    cm[addr] = data;
  endtask

  task automatic waitValid(input int start);
    lat = start;
    while (!y_valid && lat < 4 * TAPS) begin
      tick;
      lat++;
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] v, input logic withCoef,
                               input logic [AW-1:0] ca, input logic [N-1:0] cd);
    muestra_in    = v;
    muestra_valid = 1'b1;
    coef_we       = withCoef;
    coef_addr     = ca;
    coef_data     = cd;
    tick;
    muestra_valid = 1'b0;
    coef_we       = 1'b0;
    if (withCoef) cm[ca] = cd;
    modelShift(v);
    modelY(expY, expSat);
    checkOutput("busy_after_strobe", 64'(busy), 64'(1));
    checkOutput("mac_tap0_operands", 64'({Multiplicandos, Constantes}), 64'({xm[0], cm[0]}));
    waitValid(0);
    checkOutput("latency", 64'(lat), 64'(TAPS + 1));
    checkOutput("y_out", 64'(y_out), 64'(expY));
    checkOutput("sat", 64'(sat), 64'(expSat));
    checkOutput("idle_in_valid_cycle", 64'(busy), 64'(0));
  endtask

  task automatic finishSample;
    tick;
    checkOutput("y_valid_one_cycle", 64'(y_valid), 64'(0));
    checkOutput("y_out_held", 64'(y_out), 64'(expY));
    checkOutput("idle_operands_zero", 64'({Multiplicandos, Constantes}), 64'(0));
  endtask

  initial begin
    reset         = 1'b1;
    muestra_in    = '0;
    muestra_valid = 1'b0;
    coef_we       = 1'b0;
    coef_addr     = '0;
    coef_data     = '0;
    modelClear();
    #12;
    checkOutput("reset_outputs", 64'({y_out, y_valid, sat, busy}), 64'(0));
    checkOutput("reset_operands", 64'({Multiplicandos, Constantes}), 64'(0));
    checkOutput("reset_sum_ext", 64'(Sum_ext), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    tick;

    $display("[TB] identity");
    writeCoef(0, 24'd1024);
    applyStimulus(24'd5, 1'b0, '0, '0);
    checkOutput("identity_y", 64'(y_out), 64'(5));
    finishSample();

    $display("[TB] impulse response");
    doReset();
    for (int i = 0; i < TAPS; i++) writeCoef(i, N'((i + 1) * 1024));
    for (int n = 0; n <= TAPS; n++) begin
      applyStimulus((n == 0) ? 24'd1 : 24'd0, 1'b0, '0, '0);
      checkOutput("impulse_y", 64'(y_out), 64'((n < TAPS) ? n + 1 : 0));
      finishSample();
    end

    $display("[TB] saturation");
    doReset();
    writeCoef(0, 24'hFFFFFF);
    applyStimulus(24'hFFFFFF, 1'b0, '0, '0);
    checkOutput("sat_y", 64'({y_out, sat}), 64'({24'hFFFFFF, 1'b1}));
    finishSample();
    applyStimulus(24'd0, 1'b0, '0, '0);
    checkOutput("unsat_y", 64'({y_out, sat}), 64'({24'd0, 1'b0}));
    finishSample();

    $display("[TB] busy rules");
    writeCoef(0, 24'd1024);
    muestra_in    = 24'd7;
    muestra_valid = 1'b1;
    tick;
    muestra_valid = 1'b0;
    modelShift(24'd7);
    tick;
    tick;
    muestra_in    = 24'd9;
    muestra_valid = 1'b1;
    coef_we       = 1'b1;
    coef_addr     = '0;
    coef_data     = '0;
    tick;
    muestra_valid = 1'b0;
    coef_we       = 1'b0;
    waitValid(3);
    checkOutput("busy_latency", 64'(lat), 64'(TAPS + 1));
    checkOutput("busy_y7", 64'(y_out), 64'(7));
    modelY(expY, expSat);
    finishSample();
    writeCoef(1, 24'd1024);
    applyStimulus(24'd3, 1'b0, '0, '0);
    checkOutput("busy_line_and_coef_kept", 64'(y_out), 64'(10));
    finishSample();

    $display("[TB] back-to-back");
    applyStimulus(N'($urandom_range(0, 65535)), 1'b0, '0, '0);
    muestra_in    = N'($urandom_range(0, 65535));
    muestra_valid = 1'b1;
    tick;
    muestra_valid = 1'b0;
    modelShift(muestra_in);
    modelY(expY, expSat);
    waitValid(1);
    checkOutput("b2b_spacing", 64'(lat), 64'(TAPS + 2));
    checkOutput("b2b_y", 64'({y_out, sat}), 64'({expY, expSat}));
    finishSample();

    $display("[TB] random samples with coefficient updates");
    for (int r = 0; r < 20; r++) begin
      logic [N-1:0] cd;
      cd = (r % 5 == 4) ? N'($urandom) : N'($urandom_range(0, 4095));
      applyStimulus(N'($urandom), 1'($urandom), AW'($urandom), cd);
      finishSample();
    end

    $display("[TB] reset mid-MAC");
    writeCoef(0, 24'd1024);
    muestra_in    = 24'd5;
    muestra_valid = 1'b1;
    tick;
    muestra_valid = 1'b0;
    tick;
    tick;
    tick;
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midreset_outputs", 64'({y_out, y_valid, sat, busy}), 64'(0));
    checkOutput("midreset_operands", 64'({Multiplicandos, Constantes}), 64'(0));
    checkOutput("midreset_sum_ext", 64'(Sum_ext), 64'(0));
    tick;
    @(negedge clk);
    reset = 1'b0;
    modelClear();
    for (int c = 0; c < TAPS + 4; c++) begin
      tick;
      checkOutput("midreset_no_valid", 64'({y_valid, busy}), 64'(0));
    end
    applyStimulus(24'd5, 1'b0, '0, '0);
    checkOutput("coefs_lost_y", 64'(y_out), 64'(0));
    finishSample();

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
